// File: rtl/mem_pkg.sv
// Shared widths, owner and FSM encodings for the SDRAM-side arbiter (mem_arbiter).
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 24;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_req_sync.sv
// Level-handshake bookkeeping for a slow-clock master: one access per request level,
// sticky ready until the request level drops, then re-arm.
module cpu_req_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_done,
  output logic o_armed,
  output logic o_ready
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_armed <= 1'b1;
      o_ready <= 1'b0;
    end else if (i_done) begin
      o_ready <= 1'b1;
      o_armed <= 1'b0;
    end else if (o_ready && !i_req) begin
      o_ready <= 1'b0;
      o_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU, video) arbiter onto the single SDRAM controller command port.
// Define MEM_ARB_STARVE_GUARD_EN to bound video grants while the CPU waits.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned MAX_VID_STREAK = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              vid_req,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] dr_addr,
  output logic [DATA_W-1:0] dr_wdata,
  output logic              dr_read,
  output logic              dr_write,
  input  logic [DATA_W-1:0] dr_rdata,
  input  logic              dr_busy,
  input  logic              dr_ready
);

  state_e r_state;
  owner_e r_owner;
  logic   r_is_wr;
  logic   r_wait_cnt;

  logic w_cpu_req;
  logic w_cpu_armed;
  logic w_cpu_elig;
  logic w_grant_vid;
  logic w_grant_cpu;
  logic w_xfer_done;
  logic w_cpu_done;

  assign w_cpu_req  = cpu_read | cpu_write;
  assign w_cpu_elig = w_cpu_req & w_cpu_armed;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned STREAK_W = $clog2(MAX_VID_STREAK + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_cpu_first;

  assign w_cpu_first = w_cpu_elig & (r_streak == STREAK_W'(MAX_VID_STREAK));
  assign w_grant_vid = vid_req & ~w_cpu_first;

  // Count video grants made over a waiting CPU; any CPU grant or CPU-idle cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!w_cpu_elig) begin
        r_streak <= '0;
      end else if (!dr_busy) begin
        if (w_grant_vid) r_streak <= r_streak + STREAK_W'(1);
        else             r_streak <= '0;
      end
    end
  end
`else
  assign w_grant_vid = vid_req;
`endif

  assign w_grant_cpu = w_cpu_elig & ~w_grant_vid;

  // Reads finish on the data-valid pulse, writes when the controller drops busy.
  assign w_xfer_done = (r_state == ST_WAIT_DONE) && (r_is_wr ? !dr_busy : dr_ready);
  assign w_cpu_done  = w_xfer_done && (r_owner == OWN_CPU);

  cpu_req_sync u_cpu_sync (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_cpu_req),
    .i_done  (w_cpu_done),
    .o_armed (w_cpu_armed),
    .o_ready (cpu_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_CPU;
      r_is_wr    <= 1'b0;
      r_wait_cnt <= 1'b0;
      dr_addr    <= '0;
      dr_wdata   <= '0;
      dr_read    <= 1'b0;
      dr_write   <= 1'b0;
      cpu_rdata  <= '0;
      cpu_busy   <= 1'b0;
      vid_rdata  <= '0;
      vid_ack    <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!dr_busy && (w_grant_vid || w_grant_cpu)) begin
            r_state    <= ST_ISSUE;
            r_wait_cnt <= 1'b0;
            if (w_grant_vid) begin
              r_owner <= OWN_VID;
              r_is_wr <= 1'b0;
              dr_addr <= vid_addr;
              dr_read <= 1'b1;
            end else begin
              r_owner  <= OWN_CPU;
              r_is_wr  <= cpu_write;
              dr_addr  <= cpu_addr;
              dr_wdata <= cpu_wdata;
              dr_read  <= ~cpu_write;
              dr_write <= cpu_write;
              cpu_busy <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          dr_read  <= 1'b0;
          dr_write <= 1'b0;
          r_state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Give the controller two cycles to acknowledge before moving on regardless.
          if (dr_busy || r_wait_cnt) r_state <= ST_WAIT_DONE;
          else                       r_wait_cnt <= 1'b1;
        end
        ST_WAIT_DONE: begin
          if (w_xfer_done) begin
            r_state <= ST_IDLE;
            if (r_owner == OWN_VID) begin
              vid_ack   <= 1'b1;
              vid_rdata <= dr_rdata;
            end else begin
              cpu_busy <= 1'b0;
              if (!r_is_wr) cpu_rdata <= dr_rdata;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
